lut3_cfg_loader: RTL and testbench

- Configuration controller for the 3-input shift-register LUT.
- Accepts an 8-bit truth table over a valid/ready handshake.
- Serialises the table into the LUT's 8-stage shift register by sequencing its enable and serial-in lines.
- Exposes the LUT lookup (a,b,c -> z), with a z_valid qualifier that is low while the table is being rewritten.

---
 rtl/lut3_pkg.sv | 10 +
 rtl/lut3_sreg.sv | 20 ++
 rtl/lut3_cfg_loader.sv | 126 ++++++++++++
 tb/tb_lut3_cfg_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut3_pkg.sv
// Shared types and sizes for the 3-input shift-register LUT and its loader.
package lut3_pkg;
    localparam int LUT_DEPTH = 8;
    localparam int LUT_SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/lut3_sreg.sv
// 8-stage enable-gated shift register with 8:1 output select; storage is deliberately unreset.
module lut3_sreg
    import lut3_pkg::*;
(
    input  logic                 clk,
    input  logic                 enable,
    input  logic                 s,
    input  logic [LUT_SEL_W-1:0] sel,
    output logic                 z
);
    logic [LUT_DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (enable) begin
            sr_q <= {sr_q[LUT_DEPTH-2:0], s};
        end
    end

    assign z = sr_q[sel];
endmodule

// File: rtl/lut3_cfg_loader.sv
// Loads an 8-bit truth table into lut3_sreg over valid/ready, one bit every PACE cycles, MSB first.
// Define LUT3_READBACK_EN to add cfg_shadow, a copy of the last completely loaded table.
module lut3_cfg_loader
    import lut3_pkg::*;
#(
    parameter int PACE = 1
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [LUT_DEPTH-1:0] cfg_data,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    output logic                 z,
    output logic                 z_valid,
    output logic                 busy,
    output logic                 load_done
`ifdef LUT3_READBACK_EN
    ,
    output logic [LUT_DEPTH-1:0] cfg_shadow
`endif
);
    localparam int PCW = $clog2(PACE) + 1;
    localparam logic [PCW-1:0] PACE_LAST = PCW'(PACE - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(LUT_DEPTH - 1);

    state_e               state_q, state_d;
    logic [PCW-1:0]       pace_q, pace_d;
    logic [3:0]           bit_q, bit_d;
    logic [LUT_DEPTH-1:0] hold_q, hold_d;
    logic                 loaded_q, loaded_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 lut_en;
    logic                 last_step;
    logic [LUT_DEPTH-1:0] hold_rot;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign z_valid   = cfg_ready & loaded_q;
    assign load_done = done_q;
    assign accept    = cfg_valid & cfg_ready;
    assign lut_en    = busy & (pace_q == PACE_LAST);
    assign last_step = lut_en & (bit_q == BIT_LAST);
    // Rotating rather than shifting returns hold to the original table after the 8th step.
    assign hold_rot  = {hold_q[LUT_DEPTH-2:0], hold_q[LUT_DEPTH-1]};

    always_comb begin
        state_d  = state_q;
        pace_d   = pace_q;
        bit_d    = bit_q;
        hold_d   = hold_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = cfg_data;
                    pace_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (lut_en) begin
                    pace_d = '0;
                    hold_d = hold_rot;
                    bit_d  = bit_q + 4'd1;
                    if (last_step) begin
                        bit_d    = '0;
                        state_d  = IDLE;
                        loaded_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end else begin
                    pace_d = pace_q + PCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            pace_q   <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pace_q   <= pace_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

`ifdef LUT3_READBACK_EN
    logic [LUT_DEPTH-1:0] shadow_q, shadow_d;

    assign shadow_d = last_step ? hold_rot : shadow_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign cfg_shadow = shadow_q;
`endif

    lut3_sreg u_sreg (
        .clk    (clk),
        .enable (lut_en),
        .s      (hold_q[LUT_DEPTH-1]),
        .sel    ({a, b, c}),
        .z      (z)
    );
endmodule

// File: tb/tb_lut3_cfg_loader.sv
// Bench for lut3_cfg_loader: one instance at PACE=1 and one at PACE=3, checked against a table/timing model.
module tb_lut3_cfg_loader;
    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       v1 = 1'b0;
    logic       v3 = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       rdy1, zr1, zv1, busy1, ld1;
    logic       rdy3, zr3, zv3, busy3, ld3;
`ifdef LUT3_READBACK_EN
    logic [7:0] sh1, sh3;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int en_pos[$];

    // Reference model: last complete table and whether one exists, per instance (index = PACE).
    logic [7:0] model_tbl[4];
    bit         model_loaded[4];

    always #5 clk = ~clk;

    lut3_cfg_loader #(.PACE(1)) u1 (
        .clk(clk), .areset(areset), .cfg_valid(v1), .cfg_ready(rdy1), .cfg_data(cfg_data),
        .a(a), .b(b), .c(c), .z(zr1), .z_valid(zv1), .busy(busy1), .load_done(ld1)
`ifdef LUT3_READBACK_EN
        , .cfg_shadow(sh1)
`endif
    );

    lut3_cfg_loader #(.PACE(3)) u3 (
        .clk(clk), .areset(areset), .cfg_valid(v3), .cfg_ready(rdy3), .cfg_data(cfg_data),
        .a(a), .b(b), .c(c), .z(zr3), .z_valid(zv3), .busy(busy3), .load_done(ld3)
`ifdef LUT3_READBACK_EN
        , .cfg_shadow(sh3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ld(input int w);
        return (w == 1) ? ld1 : ld3;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 1) ? busy1 : busy3;
    endfunction

    function automatic logic get_zv(input int w);
        return (w == 1) ? zv1 : zv3;
    endfunction

    function automatic logic get_en(input int w);
        return (w == 1) ? u1.lut_en : u3.lut_en;
    endfunction

    // Sweeps abc 0..7 within one clock period and collects z.
    task automatic read_table(input int w, output logic [7:0] obs);
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #1;
            obs[i] = (w == 1) ? zr1 : zr3;
        end
    endtask

    // Offers t to an idle instance, then runs until load_done (bounded).
    // done_cyc counts edges from the cycle after acceptance to the load_done cycle.
    task automatic run_load(input int w, input logic [7:0] t, output int done_cyc, output int busy_cyc);
        cfg_data = t;
        if (w == 1) v1 = 1'b1; else v3 = 1'b1;
        tick();
        v1 = 1'b0;
        v3 = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        en_pos.delete();
        while (get_ld(w) !== 1'b1 && done_cyc < 400) begin
            if (get_busy(w) === 1'b1) busy_cyc++;
            if (get_en(w) === 1'b1) en_pos.push_back(done_cyc);
            tick();
            done_cyc++;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy1 got %b want 1", rdy1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        n_cmp++; if (ld1 !== 1'b0) begin n_bad++; $display("FAIL reset_ld1 got %b want 0", ld1); end
        n_cmp++; if (zv1 !== 1'b0) begin n_bad++; $display("FAIL reset_zv1 got %b want 0", zv1); end
        n_cmp++; if (rdy3 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy3 got %b want 1", rdy3); end
        n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL reset_busy3 got %b want 0", busy3); end
        n_cmp++; if (zv3 !== 1'b0) begin n_bad++; $display("FAIL reset_zv3 got %b want 0", zv3); end
        tick();
        tick();
        areset = 1'b0;
        tick();
        n_cmp++; if (zv1 !== 1'b0 || rdy1 !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle1 got zv=%b rdy=%b want zv=0 rdy=1", zv1, rdy1); end
    endtask

    task automatic test_xor3();
        int done_cyc, busy_cyc;
        logic [7:0] obs;
        bit pos_bad;
        run_load(1, 8'h96, done_cyc, busy_cyc);
        model_tbl[1] = 8'h96; model_loaded[1] = 1;
        n_cmp++; if (done_cyc + 1 != 9) begin n_bad++; $display("FAIL xor3_done_lat got %0d want 9", done_cyc + 1); end
        n_cmp++; if (busy_cyc != 8) begin n_bad++; $display("FAIL xor3_busy_cycles got %0d want 8", busy_cyc); end
        pos_bad = (en_pos.size() != 8);
        for (int j = 0; j < en_pos.size() && j < 8; j++) if (en_pos[j] != j) pos_bad = 1;
        n_cmp++; if (pos_bad) begin n_bad++; $display("FAIL xor3_enable_pulses got %0d pulses want 8 on consecutive cycles", en_pos.size()); end
        n_cmp++; if (zv1 !== 1'b1 || rdy1 !== 1'b1) begin n_bad++; $display("FAIL xor3_done_cycle got zv=%b rdy=%b want 1 1", zv1, rdy1); end
        tick();
        n_cmp++; if (ld1 !== 1'b0) begin n_bad++; $display("FAIL xor3_done_width got %b want 0", ld1); end
        read_table(1, obs);
        n_cmp++; if (obs !== model_tbl[1]) begin n_bad++; $display("FAIL xor3_table got %h want %h", obs, model_tbl[1]); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit zv_seen;
        logic [7:0] obs;
        cfg_data = 8'h80;
        v1 = 1'b1;
        tick();
        cfg_data = 8'hFE;
        cnt = 0;
        while (ld1 !== 1'b1 && cnt < 100) begin tick(); cnt++; end
        model_tbl[1] = 8'h80;
        n_cmp++; if (cnt != 8) begin n_bad++; $display("FAIL b2b_first_lat got %0d want 8", cnt); end
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_with_done got %b want 1", rdy1); end
        {a, b, c} = 3'd7; #1;
        n_cmp++; if (zr1 !== model_tbl[1][7]) begin n_bad++; $display("FAIL b2b_first_z7 got %b want %b", zr1, model_tbl[1][7]); end
        tick();
        v1 = 1'b0;
        n_cmp++; if (busy1 !== 1'b1 || zv1 !== 1'b0 || ld1 !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept got busy=%b zv=%b ld=%b want 1 0 0", busy1, zv1, ld1); end
        cnt = 0;
        zv_seen = 0;
        while (ld1 !== 1'b1 && cnt < 100) begin
            if (zv1 !== 1'b0) zv_seen = 1;
            tick();
            cnt++;
        end
        model_tbl[1] = 8'hFE;
        n_cmp++; if (zv_seen) begin n_bad++; $display("FAIL b2b_zv_during_load got 1 want 0"); end
        n_cmp++; if (cnt != 8) begin n_bad++; $display("FAIL b2b_second_lat got %0d want 8", cnt); end
        read_table(1, obs);
        n_cmp++; if (obs !== model_tbl[1]) begin n_bad++; $display("FAIL b2b_table got %h want %h", obs, model_tbl[1]); end
    endtask

    task automatic test_pace3();
        int done_cyc, busy_cyc;
        logic [7:0] obs;
        bit pos_bad;
        run_load(3, 8'h01, done_cyc, busy_cyc);
        model_tbl[3] = 8'h01; model_loaded[3] = 1;
        n_cmp++; if (done_cyc + 1 != 25) begin n_bad++; $display("FAIL pace3_done_lat got %0d want 25", done_cyc + 1); end
        n_cmp++; if (busy_cyc != 24) begin n_bad++; $display("FAIL pace3_busy_cycles got %0d want 24", busy_cyc); end
        pos_bad = (en_pos.size() != 8);
        for (int j = 0; j < en_pos.size() && j < 8; j++) if (en_pos[j] != 3 * j + 2) pos_bad = 1;
        n_cmp++; if (pos_bad) begin n_bad++; $display("FAIL pace3_enable_pulses got %0d pulses want 8 every 3rd cycle", en_pos.size()); end
        n_cmp++; if (zv3 !== 1'b1) begin n_bad++; $display("FAIL pace3_zv got %b want 1", zv3); end
        read_table(3, obs);
        n_cmp++; if (obs !== model_tbl[3]) begin n_bad++; $display("FAIL pace3_table got %h want %h", obs, model_tbl[3]); end
    endtask

    task automatic test_reset_midload();
        int done_cyc, busy_cyc;
        logic [7:0] obs;
        cfg_data = 8'hA5;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (4) tick();
        areset = 1'b1;
        #1;
        model_loaded[1] = 0;
        model_loaded[3] = 0;
        n_cmp++; if (busy1 !== 1'b0 || rdy1 !== 1'b1 || zv1 !== 1'b0) begin n_bad++; $display("FAIL abort_immediate got busy=%b rdy=%b zv=%b want 0 1 0", busy1, rdy1, zv1); end
        tick();
        areset = 1'b0;
        tick();
        n_cmp++; if (zv1 !== 1'b0 || zv3 !== 1'b0) begin n_bad++; $display("FAIL abort_zv_after_release got %b%b want 00", zv1, zv3); end
        run_load(1, 8'hA5, done_cyc, busy_cyc);
        model_tbl[1] = 8'hA5; model_loaded[1] = 1;
        n_cmp++; if (zv1 !== 1'b1 || done_cyc != 8) begin n_bad++; $display("FAIL reload_done got zv=%b lat=%0d want 1 8", zv1, done_cyc); end
        read_table(1, obs);
        n_cmp++; if (obs !== model_tbl[1]) begin n_bad++; $display("FAIL reload_table got %h want %h", obs, model_tbl[1]); end
    endtask

    task automatic test_ignored_while_busy();
        int n_done;
        logic [7:0] obs;
        cfg_data = 8'h5A;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (2) tick();
        cfg_data = 8'h3C;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (ld1 === 1'b1) n_done++;
            tick();
        end
        model_tbl[1] = 8'h5A;
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL busy_pulse_done_count got %0d want 1", n_done); end
        n_cmp++; if (busy1 !== 1'b0 || zv1 !== 1'b1) begin n_bad++; $display("FAIL busy_pulse_idle got busy=%b zv=%b want 0 1", busy1, zv1); end
        read_table(1, obs);
        n_cmp++; if (obs !== model_tbl[1]) begin n_bad++; $display("FAIL busy_pulse_table got %h want %h", obs, model_tbl[1]); end
    endtask

    task automatic test_random();
        int w, other, done_cyc, busy_cyc;
        logic [7:0] t;
        logic [2:0] s;
        logic zo;
        for (int n = 0; n < 8; n++) begin
            w = ($urandom_range(0, 1) == 0) ? 1 : 3;
            other = (w == 1) ? 3 : 1;
            t = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_load(w, t, done_cyc, busy_cyc);
            model_tbl[w] = t;
            model_loaded[w] = 1;
            n_cmp++; if (done_cyc != 8 * w || busy_cyc != 8 * w) begin n_bad++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d want %0d", n, done_cyc, busy_cyc, 8 * w); end
            n_cmp++; if (get_zv(other) !== logic'(model_loaded[other])) begin n_bad++; $display("FAIL rand%0d_other_zv got %b want %b", n, get_zv(other), model_loaded[other]); end
            for (int k = 0; k < 4; k++) begin
                s = 3'($urandom_range(0, 7));
                {a, b, c} = s;
                #1;
                zo = (w == 1) ? zr1 : zr3;
                n_cmp++; if (zo !== model_tbl[w][s]) begin n_bad++; $display("FAIL rand%0d_z sel=%0d got %b want %b", n, s, zo, model_tbl[w][s]); end
            end
        end
    endtask

`ifdef LUT3_READBACK_EN
    task automatic test_readback();
        int done_cyc, busy_cyc;
        run_load(1, 8'h96, done_cyc, busy_cyc);
        model_tbl[1] = 8'h96;
        n_cmp++; if (sh1 !== 8'h96) begin n_bad++; $display("FAIL shadow_after_load got %h want 96", sh1); end
        cfg_data = 8'h11;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (3) tick();
        n_cmp++; if (sh1 !== 8'h96) begin n_bad++; $display("FAIL shadow_during_load got %h want 96", sh1); end
        areset = 1'b1;
        #1;
        model_loaded[1] = 0;
        model_loaded[3] = 0;
        n_cmp++; if (sh1 !== 8'h00 || sh3 !== 8'h00) begin n_bad++; $display("FAIL shadow_reset got %h %h want 00 00", sh1, sh3); end
        tick();
        areset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        model_loaded[1] = 0;
        model_loaded[3] = 0;
        test_reset();
        test_xor3();
        test_back_to_back();
        test_pace3();
        test_reset_midload();
        test_ignored_while_busy();
        test_random();
`ifdef LUT3_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
